// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter using reverse double-dabble.
// Accepts DIGITS BCD digits over a valid/ready handshake. It performs one
// shift/correct step per clock and returns the binary value over a second
// valid/ready handshake. A digit above 9 produces err=1 and bin_out=0.
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BIN_W-1:0]    bin_out,
    output logic                err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_step;
    logic [CNT_W-1:0]  cnt;
    logic              bad_digit;
    logic              last_step;

    // Flag any input digit outside the range 0..9.
    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (bcd_in[4*k +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // One conversion step. The whole register shifts right by one, and
    // then 3 is subtracted from each BCD digit that is now >= 8.
    always_comb begin
        sr_step = sr >> 1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (sr_step[BIN_W + 4*k +: 4] >= 4'd8) begin
                sr_step[BIN_W + 4*k +: 4] = sr_step[BIN_W + 4*k +: 4] - 4'd3;
            end
        end
    end

    assign last_step = (cnt == CNT_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = bad_digit ? DONE : CONV;
                end
            end
            CONV: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs, decoded from state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: load the shift register, step the conversion, and latch the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr      <= '0;
            cnt     <= '0;
            bin_out <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (bad_digit) begin
                            bin_out <= '0;
                            err     <= 1'b1;
                        end else begin
                            sr  <= {bcd_in, {BIN_W{1'b0}}};
                            cnt <= CNT_W'(BIN_W);
                        end
                    end
                end
                CONV: begin
                    sr  <= sr_step;
                    cnt <= cnt - CNT_W'(1);
                    if (last_step) begin
                        bin_out <= sr_step[BIN_W-1:0];
                        err     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq. It combines table vectors,
// hand-written handshake corner cases, random stimulus against a decimal
// reference model, and an exhaustive 000..999 sweep.
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [11:0]       bcd_in;
    logic              out_valid;
    logic              out_ready;
    logic [BIN_W-1:0]  bin_out;
    logic              err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [11:0] bcd;
        int          bin;
        bit          err;
    } vec_t;

    vec_t tbl[12];

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Decimal reference model: the value of the digits, or an error for any digit above 9.
    function automatic void model(input logic [11:0] b, output int val, output bit e);
        int d;
        val = 0;
        e   = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            d = int'(b[4*k +: 4]);
            if (d > 9) e = 1'b1;
            val = val * 10 + d;
        end
        if (e) val = 0;
    endfunction

    // Present one input and wait (bounded) for the result. out_ready is held low.
    task automatic run_conv(input logic [11:0] b, output logic [BIN_W-1:0] rb,
                            output logic re, output int lat, output bit timeout);
        out_ready = 1'b0;
        bcd_in    = b;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        timeout = (out_valid !== 1'b1);
        rb = bin_out;
        re = err;
    endtask

    // Run one conversion, compare it with the expected values, then release the result.
    task automatic check_conv(input string name, input logic [11:0] b, input int exp_bin, input bit exp_err);
        logic [BIN_W-1:0] rb;
        logic             re;
        int               lat;
        bit               to;
        run_conv(b, rb, re, lat, to);
        check({name, " timeout"}, 32'(to), 32'd0);
        check({name, " bin"}, 32'(rb), 32'(exp_bin));
        check({name, " err"}, 32'(re), 32'(exp_err));
        check({name, " latency"}, 32'(lat), exp_err ? 32'd0 : 32'(BIN_W));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " release in_ready"}, 32'(in_ready), 32'd1);
        check({name, " release out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [BIN_W-1:0] rb;
        logic             re;
        int               lat;
        bit               to;
        int               mv;
        bit               me;
        logic [11:0]      rnd;
        bit               seen;

        tbl[0]  = '{12'h999, 999, 1'b0};
        tbl[1]  = '{12'h000,   0, 1'b0};
        tbl[2]  = '{12'h255, 255, 1'b0};
        tbl[3]  = '{12'h100, 100, 1'b0};
        tbl[4]  = '{12'h1A5,   0, 1'b1};
        tbl[5]  = '{12'h001,   1, 1'b0};
        tbl[6]  = '{12'hF00,   0, 1'b1};
        tbl[7]  = '{12'h059,  59, 1'b0};
        tbl[8]  = '{12'h990, 990, 1'b0};
        tbl[9]  = '{12'h00A,   0, 1'b1};
        tbl[10] = '{12'h512, 512, 1'b0};
        tbl[11] = '{12'h088,  88, 1'b0};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bcd_in = '0;
        tick(); tick();
        reset = 1'b0;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset bin_out", 32'(bin_out), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset no X", 32'($isunknown({in_ready, out_valid, bin_out, err})), 32'd0);

        for (int i = 0; i < 12; i++) begin
            check_conv($sformatf("tbl[%0d]", i), tbl[i].bcd, tbl[i].bin, tbl[i].err);
        end

        // Backpressure: the result stays stable while out_ready is low.
        run_conv(12'h059, rb, re, lat, to);
        check("bp timeout", 32'(to), 32'd0);
        for (int i = 0; i < 20; i++) begin
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp bin_out", 32'(bin_out), 32'd59);
            check("bp in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp idle keeps bin_out", 32'(bin_out), 32'd59);

        // in_valid stays high and bcd_in changes during CONV: only the first value counts.
        bcd_in = 12'h123; in_valid = 1'b1;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            check("busy in_ready", 32'(in_ready), 32'd0);
            bcd_in = 12'($urandom);
            tick();
        end
        in_valid = 1'b0;
        check("busy done seen", 32'(seen), 32'd1);
        check("busy bin_out", 32'(bin_out), 32'd123);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("busy release in_ready", 32'(in_ready), 32'd1);

        // Reset on the 5th CONV cycle discards the result in flight.
        bcd_in = 12'h321; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset in_ready", 32'(in_ready), 32'd1);
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset bin_out", 32'(bin_out), 32'd0);
        check("midreset err", 32'(err), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        check("midreset no stale result", 32'(seen), 32'd0);
        check_conv("after reset 742", 12'h742, 742, 1'b0);

        // Random stimulus against the decimal model. Half the inputs are forced to valid digits.
        for (int i = 0; i < 200; i++) begin
            if (i % 2 == 0) begin
                rnd = 12'($urandom);
            end else begin
                rnd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end
            model(rnd, mv, me);
            check_conv($sformatf("rand %03h", rnd), rnd, mv, me);
        end

        // Exhaustive sweep of every valid three-digit value.
        for (int v = 0; v < 1000; v++) begin
            rnd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            check_conv($sformatf("sweep %0d", v), rnd, v, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
